mem_ctrl: RTL and testbench

//  Sequential arbiter/sequencer between the IF and MEM stages and the single byte-wide unified RAM port.

---
 rtl/mem_ctrl_if.sv | 29 ++
 rtl/mem_ctrl.sv | 150 +++++++++++++++
 tb/tb_mem_ctrl.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_if.sv
// Request/response and RAM-port signals between the IF/MEM stages, the
// sequencer and the byte-wide unified RAM.
interface mem_ctrl_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_inst;
    logic        mem_req;
    logic        mem_we;
    logic [1:0]  mem_len;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_done;
    logic [31:0] mem_rdata;
    logic [31:0] ram_addr;
    logic [7:0]  ram_dout;
    logic        ram_wr;
    logic [7:0]  ram_din;

    modport slave (
        input  if_req, if_addr, mem_req, mem_we, mem_len, mem_addr, mem_wdata, ram_din,
        output if_done, if_inst, mem_done, mem_rdata, ram_addr, ram_dout, ram_wr
    );

    modport master (
        output if_req, if_addr, mem_req, mem_we, mem_len, mem_addr, mem_wdata, ram_din,
        input  if_done, if_inst, mem_done, mem_rdata, ram_addr, ram_dout, ram_wr
    );
endinterface

// File: rtl/mem_ctrl.sv
// Round-robin sequencer that shares one byte-wide RAM port between fetch and
// load/store, assembling multi-byte little-endian reads one byte per cycle.
module mem_ctrl #(
    parameter int RAM_RD_LAT = 1
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      rdy,
    mem_ctrl_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_DONE} state_t;

    state_t      r_state, w_next;
    logic [31:0] r_base, r_wdata, r_asm;
    logic [31:0] r_ram_addr, r_if_inst, r_mem_rdata;
    logic [7:0]  r_ram_dout;
    logic        r_ram_wr, r_if_done, r_mem_done;
    logic [1:0]  r_nm1;
    logic [2:0]  r_i;
    logic        r_owner_mem, r_last_mem;

    // One stage per cycle of RAM latency; stage RAM_RD_LAT lines up with ram_din.
    logic [RAM_RD_LAT:0]      r_vld_pipe;
    logic [RAM_RD_LAT:0][1:0] r_lane_pipe;

    logic        w_grant_mem, w_grant_any, w_g_we;
    logic [31:0] w_g_addr;
    logic [1:0]  w_g_nm1;
    logic        w_issue, w_cap, w_last_cap, w_push;
    logic [1:0]  w_cap_lane, w_push_lane;
    logic [31:0] w_asm;

    // On a tie the side that was not served last wins.
    assign w_grant_mem = bus.mem_req && (!bus.if_req || !r_last_mem);
    assign w_grant_any = bus.mem_req || bus.if_req;
    assign w_g_we      = w_grant_mem && bus.mem_we;
    assign w_g_addr    = w_grant_mem ? bus.mem_addr : bus.if_addr;
    assign w_g_nm1     = !w_grant_mem            ? 2'd3 :
                         (bus.mem_len == 2'd0)   ? 2'd0 :
                         (bus.mem_len == 2'd1)   ? 2'd1 : 2'd3;

    assign w_issue     = (r_i <= {1'b0, r_nm1});
    assign w_cap       = r_vld_pipe[RAM_RD_LAT];
    assign w_cap_lane  = r_lane_pipe[RAM_RD_LAT];
    assign w_last_cap  = (r_state == S_RD) && w_cap && (w_cap_lane == r_nm1);
    assign w_push      = ((r_state == S_IDLE) && w_grant_any && !w_g_we) ||
                         ((r_state == S_RD) && w_issue);
    assign w_push_lane = (r_state == S_RD) ? r_i[1:0] : 2'd0;

    always_comb begin
        w_asm = r_asm;
        if (w_cap)
            w_asm[{w_cap_lane, 3'b000} +: 8] = bus.ram_din;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: if (w_grant_any) w_next = w_g_we ? S_WR : S_RD;
            S_RD:   if (w_last_cap)  w_next = S_DONE;
            S_WR:   if (!w_issue)    w_next = S_DONE;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_base      <= '0;
            r_wdata     <= '0;
            r_asm       <= '0;
            r_ram_addr  <= '0;
            r_ram_dout  <= '0;
            r_ram_wr    <= 1'b0;
            r_if_inst   <= '0;
            r_mem_rdata <= '0;
            r_if_done   <= 1'b0;
            r_mem_done  <= 1'b0;
            r_nm1       <= '0;
            r_i         <= '0;
            r_owner_mem <= 1'b0;
            r_last_mem  <= 1'b0;
            r_vld_pipe  <= '0;
            r_lane_pipe <= '0;
        end else if (rdy) begin
            r_state     <= w_next;
            r_vld_pipe  <= {r_vld_pipe[RAM_RD_LAT-1:0], w_push};
            r_lane_pipe <= {r_lane_pipe[RAM_RD_LAT-1:0], w_push_lane};
            r_asm       <= w_asm;
            r_if_done   <= 1'b0;
            r_mem_done  <= 1'b0;
            unique case (r_state)
                S_IDLE: if (w_grant_any) begin
                    // Byte 0 goes out on the grant edge so the RAM sees it at T+1.
                    r_base      <= w_g_addr;
                    r_nm1       <= w_g_nm1;
                    r_wdata     <= bus.mem_wdata;
                    r_owner_mem <= w_grant_mem;
                    r_ram_addr  <= w_g_addr;
                    r_i         <= 3'd1;
                    r_asm       <= '0;
                    if (w_g_we) begin
                        r_ram_wr   <= 1'b1;
                        r_ram_dout <= bus.mem_wdata[7:0];
                    end
                end
                S_RD: begin
                    if (w_issue) begin
                        r_ram_addr <= r_base + {29'd0, r_i};
                        r_i        <= r_i + 3'd1;
                    end else begin
                        r_ram_addr <= '0;
                    end
                    if (w_last_cap) begin
                        if (r_owner_mem) begin
                            r_mem_done  <= 1'b1;
                            r_mem_rdata <= w_asm;
                        end else begin
                            r_if_done <= 1'b1;
                            r_if_inst <= w_asm;
                        end
                    end
                end
                S_WR: begin
                    if (w_issue) begin
                        r_ram_addr <= r_base + {29'd0, r_i};
                        r_ram_dout <= r_wdata[{r_i[1:0], 3'b000} +: 8];
                        r_ram_wr   <= 1'b1;
                        r_i        <= r_i + 3'd1;
                    end else begin
                        r_ram_addr <= '0;
                        r_ram_wr   <= 1'b0;
                        r_mem_done <= 1'b1;
                    end
                end
                S_DONE: r_last_mem <= r_owner_mem;
                default: ;
            endcase
        end
    end

    assign bus.ram_addr  = r_ram_addr;
    assign bus.ram_dout  = r_ram_dout;
    assign bus.ram_wr    = r_ram_wr;
    assign bus.if_done   = r_if_done;
    assign bus.if_inst   = r_if_inst;
    assign bus.mem_done  = r_mem_done;
    assign bus.mem_rdata = r_mem_rdata;
endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: transaction-level model (offsets from acceptance) checked
// every cycle, plus directed scenarios with hand-computed literals.
module tb_mem_ctrl;
    localparam int LAT = 1;

    logic clk = 1'b0;
    logic rst, rdy;
    mem_ctrl_if bus();

    mem_ctrl #(.RAM_RD_LAT(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0, n_err = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Two copies of memory: one the RAM model serves, one the model reasons about.
    logic [7:0] ram_mem [logic [31:0]];
    logic [7:0] ref_mem [logic [31:0]];

    function automatic logic [7:0] init_byte(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction
    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        return ram_mem.exists(a) ? ram_mem[a] : init_byte(a);
    endfunction
    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
    endfunction
    task automatic set_mem(input logic [31:0] a, input logic [7:0] d);
        ram_mem[a] = d;
        ref_mem[a] = d;
    endtask

    // RAM: read data appears LAT cycles after the address; the global enable freezes it too.
    logic [7:0] dpipe [LAT];
    assign bus.ram_din = dpipe[LAT-1];
    initial begin
        for (int k = 0; k < LAT; k++) dpipe[k] = 8'h00;
        forever begin
            @(posedge clk);
            if (rdy === 1'b1) begin
                if (bus.ram_wr === 1'b1) ram_mem[bus.ram_addr] = bus.ram_dout;
                for (int k = LAT - 1; k > 0; k--) dpipe[k] <= dpipe[k-1];
                dpipe[0] <= ram_rd(bus.ram_addr);
            end
        end
    end

    // Model: m_off = enabled cycles since acceptance; everything follows from it.
    bit          m_busy, m_mem, m_we, m_last_mem;
    logic [31:0] m_base, m_wd, e_inst, e_rdata;
    int          m_n, m_d, m_off;

    task automatic model_step();
        logic [31:0] w;
        if (rdy && m_busy && m_we && m_off <= m_n)
            ref_mem[m_base + 32'(m_off - 1)] = m_wd[8*(m_off-1) +: 8];
        if (rst) begin
            m_busy = 1'b0; m_last_mem = 1'b0; e_inst = '0; e_rdata = '0;
        end else if (rdy) begin
            if (m_busy) begin
                if (m_off == m_d) begin
                    m_busy = 1'b0;
                    m_last_mem = m_mem;
                end else m_off++;
            end else if (bus.if_req || bus.mem_req) begin
                m_mem  = bus.mem_req && (!bus.if_req || !m_last_mem);
                m_base = m_mem ? bus.mem_addr : bus.if_addr;
                m_n    = !m_mem ? 4 : (bus.mem_len == 2'd0) ? 1 : (bus.mem_len == 2'd1) ? 2 : 4;
                m_we   = m_mem && bus.mem_we;
                m_wd   = bus.mem_wdata;
                m_d    = m_we ? m_n + 1 : m_n + LAT + 1;
                m_off  = 1;
                m_busy = 1'b1;
            end
            if (m_busy && m_off == m_d && !m_we) begin
                w = '0;
                for (int k = 0; k < m_n; k++) w[8*k +: 8] = ref_rd(m_base + 32'(k));
                if (m_mem) e_rdata = w; else e_inst = w;
            end
        end
    endtask

    initial begin
        m_busy = 1'b0; m_last_mem = 1'b0; e_inst = '0; e_rdata = '0;
        m_off = 0; m_n = 0; m_d = 0;
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    logic [31:0] ea;
    bit          ew, eid, emd;
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            ew  = m_busy && m_we && m_off <= m_n;
            ea  = (m_busy && m_off <= m_n) ? m_base + 32'(m_off - 1) : 32'h0;
            eid = m_busy && m_off == m_d && !m_mem;
            emd = m_busy && m_off == m_d && m_mem;
            chk("ram_addr", bus.ram_addr, ea);
            chk("ram_wr", 32'(bus.ram_wr), 32'(ew));
            if (ew) chk("ram_dout", 32'(bus.ram_dout), 32'(m_wd[8*(m_off-1) +: 8]));
            chk("if_done", 32'(bus.if_done), 32'(eid));
            chk("mem_done", 32'(bus.mem_done), 32'(emd));
            chk("if_inst", bus.if_inst, e_inst);
            chk("mem_rdata", bus.mem_rdata, e_rdata);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input bit is_mem, output int c);
        c = -1;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if ((is_mem ? bus.mem_done : bus.if_done) === 1'b1) begin
                c = cyc;
                break;
            end
        end
        if (c < 0) chk(is_mem ? "mem_done_timeout" : "if_done_timeout", 32'h0, 32'h1);
    endtask

    task automatic req_mem(input bit we, input logic [1:0] len, input logic [31:0] a, input logic [31:0] wd);
        bus.mem_req = 1'b1; bus.mem_we = we; bus.mem_len = len;
        bus.mem_addr = a; bus.mem_wdata = wd;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    int c0, c, nd, got;
    logic [3:0] order;

    initial begin
        rst = 1'b1; rdy = 1'b1;
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.mem_req = 1'b0; bus.mem_we = 1'b0; bus.mem_len = '0;
        bus.mem_addr = '0; bus.mem_wdata = '0;
        set_mem(32'h100, 8'h13); set_mem(32'h101, 8'h05);
        set_mem(32'h102, 8'h00); set_mem(32'h103, 8'h00);
        set_mem(32'hFFFF_FFFF, 8'h34); set_mem(32'h0, 8'h12);
        tick();
        chk_en = 1'b1;
        tick(); tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ram_addr", bus.ram_addr, 32'h0);
        chk("rst_ram_wr", 32'(bus.ram_wr), 32'h0);
        chk("rst_if_inst", bus.if_inst, 32'h0);

        // 1: fetch only
        tick();
        bus.if_req = 1'b1; bus.if_addr = 32'h100; c0 = cyc;
        wait_done(1'b0, c);
        chk("t1_latency", 32'(c - c0), 32'd6);
        chk("t1_inst", bus.if_inst, 32'h0000_0513);
        tick(); bus.if_req = 1'b0;

        // 2: simultaneous, last grant was IF -> store first
        tick();
        req_mem(1'b1, 2'd3, 32'h200, 32'hDEAD_BEEF);
        bus.if_req = 1'b1; bus.if_addr = 32'h100; c0 = cyc;
        wait_done(1'b1, c);
        chk("t2_store_latency", 32'(c - c0), 32'd5);
        tick(); bus.mem_req = 1'b0;
        wait_done(1'b0, c);
        chk("t2_if_latency", 32'(c - c0), 32'd12);
        tick(); bus.if_req = 1'b0;
        chk("t2_ram_word", {ram_rd(32'h203), ram_rd(32'h202), ram_rd(32'h201), ram_rd(32'h200)}, 32'hDEAD_BEEF);

        // 3: both held continuously -> MEM, IF, MEM, IF
        tick();
        req_mem(1'b0, 2'd3, 32'h200, 32'h0);
        bus.if_req = 1'b1; bus.if_addr = 32'h100;
        order = '0; got = 0;
        for (int k = 0; k < 100 && got < 4; k++) begin
            @(negedge clk);
            if (bus.mem_done === 1'b1) begin order = {order[2:0], 1'b1}; got++; end
            else if (bus.if_done === 1'b1) begin order = {order[2:0], 1'b0}; got++; end
        end
        chk("t3_count", 32'(got), 32'd4);
        chk("t3_order", 32'(order), 32'b1010);
        tick(); bus.if_req = 1'b0; bus.mem_req = 1'b0;

        // 4: 2-byte load wrapping past 0xFFFFFFFF
        tick();
        req_mem(1'b0, 2'd1, 32'hFFFF_FFFF, 32'h0);
        wait_done(1'b1, c);
        chk("t4_rdata", bus.mem_rdata, 32'h0000_1234);
        tick(); bus.mem_req = 1'b0;

        // 5: three frozen cycles mid-fetch
        tick();
        bus.if_req = 1'b1; bus.if_addr = 32'h100; c0 = cyc;
        tick(); tick();
        rdy = 1'b0;
        tick(); tick(); tick();
        rdy = 1'b1;
        wait_done(1'b0, c);
        chk("t5_latency", 32'(c - c0), 32'd9);
        chk("t5_inst", bus.if_inst, 32'h0000_0513);
        tick(); bus.if_req = 1'b0;

        // 6: reset during a store at T+2
        tick();
        req_mem(1'b1, 2'd3, 32'h400, 32'h1122_3344); c0 = cyc;
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; bus.mem_req = 1'b0; bus.mem_we = 1'b0;
        @(negedge clk);
        chk("t6_wr_after_rst", 32'(bus.ram_wr), 32'h0);
        nd = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.mem_done === 1'b1) nd++;
        end
        chk("t6_no_done", 32'(nd), 32'h0);
        chk("t6_byte1_written", 32'(ram_rd(32'h401)), 32'h33);
        chk("t6_byte2_untouched", 32'(ram_rd(32'h402)), 32'(init_byte(32'h402)));
        tick();
        req_mem(1'b0, 2'd3, 32'h200, 32'h0); c0 = cyc;
        wait_done(1'b1, c);
        chk("t6_new_latency", 32'(c - c0), 32'd6);
        chk("t6_new_rdata", bus.mem_rdata, 32'hDEAD_BEEF);
        tick(); bus.mem_req = 1'b0;
        tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
